// File: rtl/match_eval_arbiter.sv
// Two-requester round-robin front end for the shared operand-match evaluator.
// Holds one registered result per grant until the consumer takes it, and keeps saturating hit counts.
module match_eval_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_a,
  input  logic             req0_b,
  input  logic [1:0]       req0_c,
  input  logic             req0_e,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_a,
  input  logic             req1_b,
  input  logic [1:0]       req1_c,
  input  logic             req1_e,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_y,
  output logic             rsp_d,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] hit_cnt0,
  output logic [CNT_W-1:0] hit_cnt1,
  output logic             busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state;
  state_t     next_state;
  logic       last_id;
  logic       match_q;
  logic       grant_valid;
  logic       grant_id;
  logic       release_rsp;
  logic [2:0] sel_a;
  logic       sel_b;
  logic [1:0] sel_c;
  logic       sel_e;
  logic [2:0] eval_res;

  // Returns {match, y, d} for one operand tuple.
  function automatic logic [2:0] evaluate(input logic [2:0] a, input logic b,
                                          input logic [1:0] c, input logic e);
    logic m;
    m = (a == 3'd2) && (c == 2'd0);
    return {m, m & b, m & e};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Round-robin grant; offered only while idle and out of reset.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!rst && (state == IDLE)) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_id;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end else begin
        grant_valid = 1'b0;
      end
    end else begin
      grant_valid = 1'b0;
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid && grant_id;

  // Steer the granted tuple into the single evaluator.
  always_comb begin
    sel_a = req0_a;
    sel_b = req0_b;
    sel_c = req0_c;
    sel_e = req0_e;
    if (grant_id) begin
      sel_a = req1_a;
      sel_b = req1_b;
      sel_c = req1_c;
      sel_e = req1_e;
    end else begin
      sel_a = req0_a;
      sel_b = req0_b;
      sel_c = req0_c;
      sel_e = req0_e;
    end
  end

  assign eval_res    = evaluate(sel_a, sel_b, sel_c, sel_e);
  assign release_rsp = (state == BUSY) && rsp_ready;

  // Next-state: accept moves to BUSY, consumer handshake returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state = BUSY;
        end else begin
          next_state = IDLE;
        end
      end
      BUSY: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = BUSY;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Result capture at accept; last_id starts at 1 so requester 0 wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id  <= 1'b0;
      rsp_y   <= 1'b0;
      rsp_d   <= 1'b0;
      match_q <= 1'b0;
      last_id <= 1'b1;
    end else if (grant_valid) begin
      rsp_id  <= grant_id;
      match_q <= eval_res[2];
      rsp_y   <= eval_res[1];
      rsp_d   <= eval_res[0];
      last_id <= grant_id;
    end
  end

  // Saturating hit counters bumped at release; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      hit_cnt0 <= {CNT_W{1'b0}};
      hit_cnt1 <= {CNT_W{1'b0}};
    end else if (release_rsp && match_q) begin
      if (rsp_id) begin
        hit_cnt1 <= sat_inc(hit_cnt1);
      end else begin
        hit_cnt0 <= sat_inc(hit_cnt0);
      end
    end
  end

  assign rsp_valid = (state == BUSY);
  assign busy      = (state == BUSY);

endmodule

// File: tb/tb_match_eval_arbiter.sv
// Randomized and directed bench for match_eval_arbiter against a transaction-level reference model.
module tb_match_eval_arbiter;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_a, req1_a;
  logic             req0_b, req1_b;
  logic [1:0]       req0_c, req1_c;
  logic             req0_e, req1_e;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_y, rsp_d;
  logic             clr_cnt;
  logic [CNT_W-1:0] hit_cnt0, hit_cnt1;
  logic             busy;

  match_eval_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c(req0_c), .req0_e(req0_e),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c(req1_c), .req1_e(req1_e),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_d(rsp_d), .clr_cnt(clr_cnt), .hit_cnt0(hit_cnt0), .hit_cnt1(hit_cnt1), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one pending result slot, a fairness pointer and two counters.
  int m_busy, m_last, m_id, m_y, m_d, m_match;
  int m_cnt [2];
  int acc0, acc1;
  int ids [$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_id = 0; m_y = 0; m_d = 0; m_match = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // One clock cycle: inputs already driven after the falling edge.
  task automatic step();
    int er0, er1, id, a, c, b, e, mt;
    #1;
    er0 = (!rst && !m_busy && req0_valid && (!req1_valid || m_last == 1)) ? 1 : 0;
    er1 = (!rst && !m_busy && req1_valid && (!req0_valid || m_last == 0)) ? 1 : 0;
    check_eq("req0_ready", int'(req0_ready), er0);
    check_eq("req1_ready", int'(req1_ready), er1);
    check_eq("rsp_valid", int'(rsp_valid), m_busy);
    check_eq("busy", int'(busy), m_busy);
    if (m_busy != 0) begin
      check_eq("rsp_id", int'(rsp_id), m_id);
      check_eq("rsp_y", int'(rsp_y), m_y);
      check_eq("rsp_d", int'(rsp_d), m_d);
    end
    check_eq("hit_cnt0", int'(hit_cnt0), m_cnt[0]);
    check_eq("hit_cnt1", int'(hit_cnt1), m_cnt[1]);
    if (rsp_valid) ids.push_back(int'(rsp_id));
    acc0 = er0;
    acc1 = er1;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_busy != 0 && rsp_ready) begin
        m_busy = 0;
        if (m_match != 0 && m_cnt[m_id] < CNT_MAX) m_cnt[m_id] = m_cnt[m_id] + 1;
      end
      if (clr_cnt) begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end
      if (er0 != 0 || er1 != 0) begin
        id = er1;
        a  = (id != 0) ? int'(req1_a) : int'(req0_a);
        b  = (id != 0) ? int'(req1_b) : int'(req0_b);
        c  = (id != 0) ? int'(req1_c) : int'(req0_c);
        e  = (id != 0) ? int'(req1_e) : int'(req0_e);
        mt = (a == 2 && c == 0) ? 1 : 0;
        m_match = mt;
        m_y = mt * b;
        m_d = mt * e;
        m_id = id;
        m_last = id;
        m_busy = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_ops0();
    req0_a = ($urandom_range(1, 0) == 1) ? 3'd2 : 3'($urandom_range(7, 0));
    req0_c = ($urandom_range(1, 0) == 1) ? 2'd0 : 2'($urandom_range(3, 0));
    req0_b = 1'($urandom_range(1, 0));
    req0_e = 1'($urandom_range(1, 0));
  endtask

  task automatic rand_ops1();
    req1_a = ($urandom_range(1, 0) == 1) ? 3'd2 : 3'($urandom_range(7, 0));
    req1_c = ($urandom_range(1, 0) == 1) ? 2'd0 : 2'($urandom_range(3, 0));
    req1_b = 1'($urandom_range(1, 0));
    req1_e = 1'($urandom_range(1, 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set0(input logic [2:0] a, input logic b, input logic [1:0] c, input logic e);
    req0_a = a; req0_b = b; req0_c = c; req0_e = e;
  endtask

  task automatic set1(input logic [2:0] a, input logic b, input logic [1:0] c, input logic e);
    req1_a = a; req1_b = b; req1_c = c; req1_e = e;
  endtask

  initial begin
    rst = 1'b1; clr_cnt = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    set0(3'd0, 1'b0, 2'd0, 1'b0);
    set1(3'd0, 1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Single request from requester 0
    rsp_ready = 1'b1;
    req0_valid = 1'b1; set0(3'd2, 1'b1, 2'd0, 1'b0);
    step();
    check_eq("single_ready_pulse", acc0, 1);
    req0_valid = 1'b0;
    step();
    step();
    check_eq("single_cnt0", int'(hit_cnt0), 1);

    // Contention: strict alternation, one result every 2 cycles
    do_reset();
    ids.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    rand_ops0(); rand_ops1();
    for (int i = 0; i < 16; i++) begin
      step();
      if (acc0 != 0) rand_ops0();
      if (acc1 != 0) rand_ops1();
    end
    check_eq("contention_results", ids.size(), 8);
    for (int k = 0; k < ids.size(); k++) check_eq("contention_id", ids[k], k % 2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Non-match then d-only match on requester 1
    do_reset();
    req1_valid = 1'b1; set1(3'd2, 1'b1, 2'd1, 1'b1);
    step(); req1_valid = 1'b0;
    step();
    step();
    check_eq("nonmatch_cnt1", int'(hit_cnt1), 0);
    req1_valid = 1'b1; set1(3'd2, 1'b0, 2'd0, 1'b1);
    step(); req1_valid = 1'b0;
    check_eq("dmatch_y", int'(rsp_y), 0);
    check_eq("dmatch_d", int'(rsp_d), 1);
    step();
    step();
    check_eq("dmatch_cnt1", int'(hit_cnt1), 1);

    // Back-pressure for 5 cycles with requester 1 waiting
    rsp_ready = 1'b0;
    req0_valid = 1'b1; set0(3'd2, 1'b1, 2'd0, 1'b1);
    step(); req0_valid = 1'b0;
    req1_valid = 1'b1; set1(3'd2, 1'b1, 2'd0, 1'b0);
    repeat (5) step();
    rsp_ready = 1'b1;
    step();
    step();
    req1_valid = 1'b0;
    step();
    step();

    // Reset while BUSY drops the result; requester 0 wins afterwards
    rsp_ready = 1'b0;
    req1_valid = 1'b1; set1(3'd2, 1'b1, 2'd0, 1'b1);
    step(); req1_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_drops_valid", int'(rsp_valid), 0);
    check_eq("rst_no_count", int'(hit_cnt1), 0);
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    step();
    check_eq("rst_winner_req0", acc0, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    // Saturation at 2^CNT_W-1 and clear coinciding with a release
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; set0(3'd2, 1'($urandom_range(1, 0)), 2'd0, 1'($urandom_range(1, 0)));
      step(); req0_valid = 1'b0;
      step();
      step();
      check_eq("sat_cnt0", int'(hit_cnt0), (k + 1 < CNT_MAX) ? k + 1 : CNT_MAX);
    end
    req0_valid = 1'b1; set0(3'd2, 1'b1, 2'd0, 1'b1);
    step(); req0_valid = 1'b0;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    step();
    check_eq("clr_on_release", int'(hit_cnt0), 0);

    // Randomized traffic: valids held until accepted, random back-pressure, clears and resets
    for (int i = 0; i < 800; i++) begin
      if (req0_valid && acc0 != 0) req0_valid = 1'b0;
      if (req1_valid && acc1 != 0) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(1, 0) == 1) begin req0_valid = 1'b1; rand_ops0(); end
      if (!req1_valid && $urandom_range(1, 0) == 1) begin req1_valid = 1'b1; rand_ops1(); end
      rsp_ready = ($urandom_range(3, 0) != 0);
      clr_cnt   = ($urandom_range(31, 0) == 0);
      rst       = ($urandom_range(96, 0) == 0);
      acc0 = 0; acc1 = 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_eval_arbiter.md
# match_eval_arbiter

Two-requester arbiter and sequencer for the shared operand-match evaluator: `a[2:0]`, `b`, `c[1:0]` and `e` produce `y` and `d`. It accepts operand tuples from two independent valid/ready requesters and grants round-robin. It evaluates the granted tuple once through the single match unit, registers the result with the requester ID, and holds it until the consumer accepts it. Per-requester saturating hit counters provide statistics.

## Interface
Parameters:
- `CNT_W`, default 8, width of each hit counter.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a tuple.
- `req0_ready`  out  1  requester 0 tuple accepted this cycle.
- `req0_a`  in  3, `req0_b`  in  1, `req0_c`  in  2, `req0_e`  in  1  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_c`, `req1_e`  same as requester 0, for requester 1.
- `rsp_valid`  out  1  result held for consumer.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_id`  out  1  requester that owns the result.
- `rsp_y`  out  1  registered `y`.
- `rsp_d`  out  1  registered `d`.
- `clr_cnt`  in  1  synchronous clear of both hit counters.
- `hit_cnt0`  out  CNT_W  match count for requester 0.
- `hit_cnt1`  out  CNT_W  match count for requester 1.
- `busy`  out  1  high while state is BUSY.

## Operation
- Evaluator, combinational on the granted tuple:
  - `match = (a == 3'd2) && (c == 2'd0)`
  - `y = match & b`
  - `d = match & e`
- FSM has two states.
  - IDLE: `rsp_valid = 0`, `busy = 0`.
  - BUSY: `rsp_valid = 1`, `busy = 1`.
- Grant, computed in IDLE only:
  - only `req0_valid` high → grant 0; only `req1_valid` high → grant 1.
  - both high → grant the requester that is not `last_id`.
  - neither high → no grant.
- `reqN_ready = (state == IDLE) && grant == N`.
  - Combinational from the valids.
  - Requesters must not make `valid` depend on `ready`.
  - Requesters must hold `valid` and operands stable until `ready`.
- Accept, when `reqN_valid && reqN_ready` in IDLE:
  - register `rsp_y`, `rsp_d`, `rsp_id = N` and the match bit;
  - set `last_id = N`;
  - go to BUSY.
- BUSY:
  - outputs hold stable; both `ready` outputs are 0.
  - `rsp_valid && rsp_ready` → return to IDLE; if the stored match bit is 1, increment `hit_cnt[rsp_id]`.
  - No new accept in the same cycle as a release; IDLE spends at least one cycle.
- Counters:
  - saturate at 2^CNT_W−1; no wrap.
  - `clr_cnt` overrides any increment in the same cycle.
- Reset values:
  - state IDLE; `rsp_valid`, `rsp_y`, `rsp_d`, `rsp_id`, `busy` = 0.
  - `last_id = 1`, so requester 0 wins the first contention.
  - `hit_cnt0 = hit_cnt1 = 0`; both `ready` outputs are 0 while `rst` is high.
- Reset mid-operation drops any pending result with no counter update. `rsp_valid` is 0 in the cycle after `rst` is sampled.

## Timing
- Latency: accept edge T → `rsp_valid` high from cycle T+1.
- Release: the consumer handshake at edge R puts the block in IDLE at R+1. The earliest next accept is at edge R+1, so peak throughput is one result per 2 cycles.
- `rsp_*` registered outputs; `reqN_ready` combinational from the `reqN_valid` inputs and state.
- Counters update at the release edge and are visible the next cycle.
- Back-pressure: `rsp_ready` low holds BUSY indefinitely with outputs unchanged.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1…

## Test plan
- **Single request.** After reset, `req0` presents `a=2`, `c=0`, `b=1`, `e=0` with `rsp_ready=1`.
  - `req0_ready` pulses once.
  - Next cycle: `rsp_valid=1`, `rsp_id=0`, `y=1`, `d=0`.
  - `hit_cnt0=1` after release.
- **Contention.** Both requesters hold valid for 8 results, `rsp_ready=1`.
  - `rsp_id` sequence is 0,1,0,1,0,1,0,1.
  - Each result takes 2 cycles.
- **Non-match and counters.** `req1` sends `a=2`, `c=1`, `b=1`, `e=1`.
  - `y=0`, `d=0`, `hit_cnt1` unchanged.
  - With `a=2`, `c=0`, `b=0`, `e=1`: `y=0`, `d=1`, and `hit_cnt1` increments.
- **Back-pressure and reset.** Hold `rsp_ready=0` for 5 cycles, then release.
  - `rsp_*` are stable and both `ready` outputs are 0 throughout.
  - Repeat, asserting `rst` mid-BUSY: `rsp_valid=0` next cycle, no count, and `req0` wins the next contention.
- **Saturation and clear.** With `CNT_W=2`, send 5 matching `req0` tuples.
  - `hit_cnt0` reads 1,2,3,3,3.
  - `clr_cnt` coinciding with a release leaves `hit_cnt0=0`.
